fabric_config_loader: RTL and testbench
=======================================

# fabric_config_loader

Serial bitstream loader that sits directly upstream of the logic-tile / switch-box fabric. It accepts a bit-serial configuration stream with a valid/ready handshake and hunts for a sync word. It then deframes 33-bit tile frames (LUT contents plus FF-select bit) and 16-bit switch-box frames, and issues one parallel write per frame into the fabric's configuration storage. A trailing checksum decides whether the fabric is enabled.

## Interface
- NUM_TILES, 24, logic tiles to configure (frame width 33: bits 0–31 LUT, bit 32 register-select)
- NUM_SWITCHES, 17, 4x4 switch boxes to configure (frame width 16)
- SYNC_WORD, 8'hA5, stream sync pattern
- clock  in  1  single clock, all logic on posedge
- reset_n  in  1  synchronous, active-low reset
- cfg_start  in  1  one-cycle pulse: abort/restart, return to sync hunt
- cfg_bit  in  1  serial data, LSB of each field first
- cfg_valid  in  1  cfg_bit valid this cycle
- cfg_ready  out  1  loader accepts a bit this cycle
- tile_we  out  1  one-cycle tile frame write strobe
- tile_addr  out  $clog2(NUM_TILES)  tile index
- tile_data  out  33  tile frame
- sw_we  out  1  one-cycle switch frame write strobe
- sw_addr  out  $clog2(NUM_SWITCHES)  switch index
- sw_data  out  16  switch frame
- cfg_done  out  1  load complete, checksum good (level)
- cfg_error  out  1  checksum mismatch (level)
- fabric_enable  out  1  equals cfg_done; gates fabric clock-enable downstream

## Operation
- Bit accepted only when cfg_valid && cfg_ready; cfg_valid low stalls every counter and state.
- States: HUNT, TILE, SWITCH, CHECK, DONE, ERROR.
- HUNT: shift accepted bits into 8-bit window (new bit enters at MSB, window shifts right, so first-received bit lands in bit 0); window == SYNC_WORD -> TILE. Overlapping matches allowed; window cleared on entry to HUNT.
- TILE: collect 33 bits into frame shifter; after 33rd bit, write frame to tile_addr = tile counter, increment. After frame NUM_TILES-1 -> SWITCH.
- SWITCH: same with 16-bit frames, sw counter; after frame NUM_SWITCHES-1 -> CHECK.
- Checksum: every payload bit (tile and switch frames only, not sync, not checksum) number i is XORed into chk[i mod 8]; i restarts at 0 on leaving HUNT. Default payload 1064 bits.
- CHECK: receive 8 bits LSB first; equal to chk -> DONE, else ERROR.
- DONE/ERROR: cfg_ready low; hold until cfg_start or reset.
- cfg_start in any state: next cycle HUNT, all counters, window, chk cleared, cfg_done/cfg_error/fabric_enable low; the bit presented in the cfg_start cycle is discarded. cfg_start wins over a simultaneous accepted bit.
- Writes already issued before an error or restart are not undone; fabric_enable low is the protection.

## Timing
- During reset and first cycle after reset_n rises: all outputs 0 except addr/data (0). cfg_ready = 1 from the first cycle in HUNT.
- cfg_ready is a registered function of state only (1 in HUNT/TILE/SWITCH/CHECK).
- Write latency: tile_we/sw_we high exactly one cycle, the cycle after the frame's last bit is accepted; addr/data stable that cycle.
- State change to TILE occurs the cycle after the completing sync bit; first payload bit may be accepted in that cycle.
- cfg_done/cfg_error/fabric_enable rise the cycle after the 8th checksum bit is accepted.
- Back-to-back stream (valid always 1): sync+payload+checksum = 1080 accepted bits; cfg_done high at cycle 1081 after first accepted bit.
- Reset mid-load: same as cfg_start plus all outputs cleared same edge.

## Structure
- Package fabric_cfg_pkg: state enum, SYNC_WORD, TILE_FRAME_W=33, SW_FRAME_W=16, CHK_W=8.
- One sub-module: cfg_frame_shifter (width-parameterised serial-in/parallel-out with bit counter and frame_full pulse), instantiated once, width selected by state (counter terminal value 32 or 15).

## Test plan
- Reset then clean stream (sync A5, tile k LUT = 32'h0000_0001<<k, bit32 = k[0], switch s = 16'h8421^s, correct chk) -> 24 tile_we with those values at addr 0..23, 17 sw_we, cfg_done=fabric_enable=1, cfg_ready=0.
- Same stream with one payload bit flipped -> all writes issued, cfg_error=1, fabric_enable=0.
- Noise 1,0,1,1,0 before sync and partial A5 (bits of 8'h25) -> stays HUNT, no writes until true A5.
- cfg_valid toggled randomly 50% -> identical write sequence and done, only timing stretched.
- cfg_start asserted mid tile frame 5 -> HUNT next cycle, outputs clear; resent full stream loads from tile 0 correctly.
- reset_n low for one cycle during SWITCH -> all outputs 0 next cycle, cfg_ready 1 after release.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared types and constants for the serial fabric configuration loader.
// Frame widths, sync pattern and the loader state encoding live here.
package fabric_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_TILE,
    ST_SWITCH,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } cfg_state_e;

  localparam logic [7:0] SYNC_WORD    = 8'hA5;
  localparam int         TILE_FRAME_W = 33;
  localparam int         SW_FRAME_W   = 16;
  localparam int         CHK_W        = 8;

  // The loader only takes stream bits while it still has something to receive.
  function automatic logic state_ready(input cfg_state_e s);
    return (s == ST_HUNT) || (s == ST_TILE) || (s == ST_SWITCH) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/cfg_frame_shifter.sv
// Serial-in/parallel-out frame collector shared by tile and switch-box frames.
// Bits land LSB first; frame_full and frame_data are combinational views of the completing bit.
module cfg_frame_shifter #(
  parameter  int MAX_W = fabric_cfg_pkg::TILE_FRAME_W,
  localparam int CNT_W = $clog2(MAX_W)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] last_idx,
  output logic             frame_full,
  output logic [MAX_W-1:0] frame_data
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [MAX_W-1:0] data_q, data_d;

  // A new frame starts from zero so narrow frames carry no stale upper bits.
  always_comb begin
    cnt_d      = cnt_q;
    data_d     = data_q;
    frame_full = 1'b0;
    if (clear) begin
      cnt_d  = '0;
      data_d = '0;
    end else if (shift_en) begin
      if (cnt_q == '0) begin
        data_d = '0;
      end
      data_d[cnt_q] = bit_in;
      if (cnt_q == last_idx) begin
        frame_full = 1'b1;
        cnt_d      = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  assign frame_data = data_d;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/fabric_config_loader.sv
// Bit-serial configuration loader: sync hunt, tile/switch frame deframing with one write per
// frame, and a trailing interleaved-XOR checksum that decides whether the fabric is enabled.
module fabric_config_loader #(
  parameter  int         NUM_TILES    = 24,
  parameter  int         NUM_SWITCHES = 17,
  parameter  logic [7:0] SYNC_WORD    = fabric_cfg_pkg::SYNC_WORD,
  localparam int         TILE_AW      = $clog2(NUM_TILES),
  localparam int         SW_AW        = $clog2(NUM_SWITCHES)
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  cfg_start,
  input  logic                                  cfg_bit,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic                                  tile_we,
  output logic [TILE_AW-1:0]                    tile_addr,
  output logic [fabric_cfg_pkg::TILE_FRAME_W-1:0] tile_data,
  output logic                                  sw_we,
  output logic [SW_AW-1:0]                      sw_addr,
  output logic [fabric_cfg_pkg::SW_FRAME_W-1:0]   sw_data,
  output logic                                  cfg_done,
  output logic                                  cfg_error,
  output logic                                  fabric_enable
);

  import fabric_cfg_pkg::*;

  localparam int                 SHIFT_CW  = $clog2(TILE_FRAME_W);
  localparam int                 PIDX_W    = $clog2(CHK_W);
  localparam logic [TILE_AW-1:0] LAST_TILE = TILE_AW'(NUM_TILES - 1);
  localparam logic [SW_AW-1:0]   LAST_SW   = SW_AW'(NUM_SWITCHES - 1);

  cfg_state_e state_q, state_d;

  logic [7:0]        window_q, window_d;
  logic [TILE_AW-1:0] tile_cnt_q, tile_cnt_d;
  logic [SW_AW-1:0]   sw_cnt_q, sw_cnt_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic [PIDX_W-1:0]  pay_idx_q, pay_idx_d;
  logic [CHK_W-1:0]   chk_rx_q, chk_rx_d;
  logic [PIDX_W-1:0]  chk_cnt_q, chk_cnt_d;

  logic                     ready_q, ready_d;
  logic                     tile_we_q, tile_we_d;
  logic [TILE_AW-1:0]       tile_addr_q, tile_addr_d;
  logic [TILE_FRAME_W-1:0]  tile_data_q, tile_data_d;
  logic                     sw_we_q, sw_we_d;
  logic [SW_AW-1:0]         sw_addr_q, sw_addr_d;
  logic [SW_FRAME_W-1:0]    sw_data_q, sw_data_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic                    accept;
  logic                    shift_en;
  logic [SHIFT_CW-1:0]     last_idx;
  logic                    frame_full;
  logic [TILE_FRAME_W-1:0] frame_data;

  assign accept   = cfg_valid && ready_q;
  assign shift_en = accept && ((state_q == ST_TILE) || (state_q == ST_SWITCH));
  assign last_idx = (state_q == ST_TILE) ? SHIFT_CW'(TILE_FRAME_W - 1) : SHIFT_CW'(SW_FRAME_W - 1);

  cfg_frame_shifter #(
    .MAX_W(TILE_FRAME_W)
  ) u_frame_shifter (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (cfg_start),
    .shift_en  (shift_en),
    .bit_in    (cfg_bit),
    .last_idx  (last_idx),
    .frame_full(frame_full),
    .frame_data(frame_data)
  );

  // Payload bit i folds into chk[i mod 8]; restart clears every counter and the sync window.
  always_comb begin
    window_d   = window_q;
    tile_cnt_d = tile_cnt_q;
    sw_cnt_d   = sw_cnt_q;
    chk_d      = chk_q;
    pay_idx_d  = pay_idx_q;
    chk_rx_d   = chk_rx_q;
    chk_cnt_d  = chk_cnt_q;
    if (cfg_start) begin
      window_d   = '0;
      tile_cnt_d = '0;
      sw_cnt_d   = '0;
      chk_d      = '0;
      pay_idx_d  = '0;
      chk_rx_d   = '0;
      chk_cnt_d  = '0;
    end else if (accept) begin
      case (state_q)
        ST_HUNT: window_d = {cfg_bit, window_q[7:1]};
        ST_TILE, ST_SWITCH: begin
          chk_d[pay_idx_q] = chk_q[pay_idx_q] ^ cfg_bit;
          pay_idx_d        = pay_idx_q + PIDX_W'(1);
          if (frame_full && (state_q == ST_TILE)) begin
            tile_cnt_d = tile_cnt_q + TILE_AW'(1);
          end
          if (frame_full && (state_q == ST_SWITCH)) begin
            sw_cnt_d = sw_cnt_q + SW_AW'(1);
          end
        end
        ST_CHECK: begin
          chk_rx_d  = {cfg_bit, chk_rx_q[CHK_W-1:1]};
          chk_cnt_d = chk_cnt_q + PIDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (cfg_start) begin
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: begin
          if (accept && (window_d == SYNC_WORD)) state_d = ST_TILE;
        end
        ST_TILE: begin
          if (frame_full && (tile_cnt_q == LAST_TILE)) state_d = ST_SWITCH;
        end
        ST_SWITCH: begin
          if (frame_full && (sw_cnt_q == LAST_SW)) state_d = ST_CHECK;
        end
        ST_CHECK: begin
          if (accept && (chk_cnt_q == PIDX_W'(CHK_W - 1))) begin
            state_d = (chk_rx_d == chk_q) ? ST_DONE : ST_ERROR;
          end
        end
        ST_DONE:  state_d = ST_DONE;
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_HUNT;
      endcase
    end
  end

  // Outputs are registered from the next state, so they move on the same edge as the state.
  always_comb begin
    ready_d     = state_ready(state_d);
    done_d      = (state_d == ST_DONE);
    error_d     = (state_d == ST_ERROR);
    tile_we_d   = 1'b0;
    tile_addr_d = tile_addr_q;
    tile_data_d = tile_data_q;
    sw_we_d     = 1'b0;
    sw_addr_d   = sw_addr_q;
    sw_data_d   = sw_data_q;
    if (cfg_start) begin
      tile_addr_d = '0;
      tile_data_d = '0;
      sw_addr_d   = '0;
      sw_data_d   = '0;
    end else if (frame_full) begin
      if (state_q == ST_TILE) begin
        tile_we_d   = 1'b1;
        tile_addr_d = tile_cnt_q;
        tile_data_d = frame_data;
      end else begin
        sw_we_d   = 1'b1;
        sw_addr_d = sw_cnt_q;
        sw_data_d = frame_data[SW_FRAME_W-1:0];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      window_d_reset_block: begin
        window_q    <= '0;
        tile_cnt_q  <= '0;
        sw_cnt_q    <= '0;
        chk_q       <= '0;
        pay_idx_q   <= '0;
        chk_rx_q    <= '0;
        chk_cnt_q   <= '0;
        ready_q     <= 1'b0;
        tile_we_q   <= 1'b0;
        tile_addr_q <= '0;
        tile_data_q <= '0;
        sw_we_q     <= 1'b0;
        sw_addr_q   <= '0;
        sw_data_q   <= '0;
        done_q      <= 1'b0;
        error_q     <= 1'b0;
      end
    end else begin
      window_q    <= window_d;
      tile_cnt_q  <= tile_cnt_d;
      sw_cnt_q    <= sw_cnt_d;
      chk_q       <= chk_d;
      pay_idx_q   <= pay_idx_d;
      chk_rx_q    <= chk_rx_d;
      chk_cnt_q   <= chk_cnt_d;
      ready_q     <= ready_d;
      tile_we_q   <= tile_we_d;
      tile_addr_q <= tile_addr_d;
      tile_data_q <= tile_data_d;
      sw_we_q     <= sw_we_d;
      sw_addr_q   <= sw_addr_d;
      sw_data_q   <= sw_data_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign cfg_ready     = ready_q;
  assign tile_we       = tile_we_q;
  assign tile_addr     = tile_addr_q;
  assign tile_data     = tile_data_q;
  assign sw_we         = sw_we_q;
  assign sw_addr       = sw_addr_q;
  assign sw_data       = sw_data_q;
  assign cfg_done      = done_q;
  assign cfg_error     = error_q;
  assign fabric_enable = done_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed bench for fabric_config_loader: clean, corrupted, noisy, stalled, restarted
// and reset-interrupted configuration streams against a bench-built expected frame set.
module tb_fabric_config_loader;

  localparam int NUM_TILES    = 24;
  localparam int NUM_SWITCHES = 17;
  localparam int TOTAL_BITS   = 8 + NUM_TILES * 33 + NUM_SWITCHES * 16 + 8;

  logic        clock;
  logic        reset_n;
  logic        cfg_start;
  logic        cfg_bit;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        tile_we;
  logic [4:0]  tile_addr;
  logic [32:0] tile_data;
  logic        sw_we;
  logic [4:0]  sw_addr;
  logic [15:0] sw_data;
  logic        cfg_done;
  logic        cfg_error;
  logic        fabric_enable;

  int n_compared = 0;
  int n_mismatch = 0;
  int tile_seen  = 0;
  int sw_seen    = 0;
  bit aborted    = 0;

  logic [32:0] exp_tile [NUM_TILES];
  logic [15:0] exp_sw   [NUM_SWITCHES];
  logic [7:0]  exp_chk;
  bit          stream_q [$];

  fabric_config_loader #(
    .NUM_TILES   (NUM_TILES),
    .NUM_SWITCHES(NUM_SWITCHES),
    .SYNC_WORD   (8'hA5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .cfg_start    (cfg_start),
    .cfg_bit      (cfg_bit),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .tile_we      (tile_we),
    .tile_addr    (tile_addr),
    .tile_data    (tile_data),
    .sw_we        (sw_we),
    .sw_addr      (sw_addr),
    .sw_data      (sw_data),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .fabric_enable(fabric_enable)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_compared++;
    assert (observed === expected)
    else begin
      n_mismatch++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Frames: tile k = {k[0], 1<<k}, switch s = 8421^s; checksum folds payload bit i into chk[i%8].
  task automatic buildStream(input bit flip);
    logic [7:0] sync_v;
    int         idx;
    sync_v  = 8'hA5;
    idx     = 0;
    exp_chk = 8'h00;
    stream_q.delete();
    for (int b = 0; b < 8; b++) stream_q.push_back(sync_v[b]);
    for (int k = 0; k < NUM_TILES; k++) begin
      exp_tile[k] = {1'(k & 1), 32'h0000_0001 << k};
      for (int b = 0; b < 33; b++) begin
        stream_q.push_back(exp_tile[k][b]);
        exp_chk[idx % 8] = exp_chk[idx % 8] ^ exp_tile[k][b];
        idx++;
      end
    end
    for (int s = 0; s < NUM_SWITCHES; s++) begin
      exp_sw[s] = 16'h8421 ^ 16'(s);
      for (int b = 0; b < 16; b++) begin
        stream_q.push_back(exp_sw[s][b]);
        exp_chk[idx % 8] = exp_chk[idx % 8] ^ exp_sw[s][b];
        idx++;
      end
    end
    for (int b = 0; b < 8; b++) stream_q.push_back(exp_chk[b]);
    if (flip) begin
      exp_tile[3][7]         = ~exp_tile[3][7];
      stream_q[8 + 3*33 + 7] = ~stream_q[8 + 3*33 + 7];
    end
  endtask

  task automatic sendBit(input bit b, input bit stall_en);
    int guard = 0;
    bit taken = 0;
    if (aborted) return;
    while (!taken && guard < 100) begin
      @(negedge clock);
      guard++;
      if (stall_en && ($urandom_range(0, 1) == 0)) begin
        cfg_valid = 1'b0;
      end else begin
        cfg_valid = 1'b1;
        cfg_bit   = b;
        taken     = (cfg_ready === 1'b1);
      end
    end
    if (!taken) begin
      checkOutput("accept_timeout", 64'(taken), 64'd1);
      aborted = 1;
    end
  endtask

  task automatic applyStimulus(input bit stall_en, input int nbits);
    for (int i = 0; i < nbits; i++) sendBit(stream_q[i], stall_en);
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  task automatic pulseStart();
    @(negedge clock);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_bit   = 1'b1;
    @(negedge clock);
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    tile_seen = 0;
    sw_seen   = 0;
  endtask

  task automatic checkIdle();
    checkOutput("idle_ready", 64'(cfg_ready), 64'd0);
    checkOutput("idle_tile_we", 64'(tile_we), 64'd0);
    checkOutput("idle_tile_addr", 64'(tile_addr), 64'd0);
    checkOutput("idle_tile_data", 64'(tile_data), 64'd0);
    checkOutput("idle_sw_we", 64'(sw_we), 64'd0);
    checkOutput("idle_sw_addr", 64'(sw_addr), 64'd0);
    checkOutput("idle_sw_data", 64'(sw_data), 64'd0);
    checkOutput("idle_done", 64'(cfg_done), 64'd0);
    checkOutput("idle_error", 64'(cfg_error), 64'd0);
    checkOutput("idle_enable", 64'(fabric_enable), 64'd0);
  endtask

  task automatic checkLoaded(input bit good);
    checkOutput("tile_write_total", 64'(tile_seen), 64'(NUM_TILES));
    checkOutput("sw_write_total", 64'(sw_seen), 64'(NUM_SWITCHES));
    checkOutput("done_level", 64'(cfg_done), 64'(good));
    checkOutput("error_level", 64'(cfg_error), 64'(!good));
    checkOutput("enable_level", 64'(fabric_enable), 64'(good));
    checkOutput("ready_after_load", 64'(cfg_ready), 64'd0);
  endtask

  // Every write strobe is matched against the next expected frame in order.
  always @(negedge clock) begin
    if (tile_we === 1'b1) begin
      if (tile_seen < NUM_TILES) begin
        checkOutput("tile_addr", 64'(tile_addr), 64'(tile_seen));
        checkOutput("tile_data", 64'(tile_data), 64'(exp_tile[tile_seen]));
      end else begin
        checkOutput("tile_write_overflow", 64'(tile_seen), 64'(NUM_TILES - 1));
      end
      tile_seen++;
    end
    if (sw_we === 1'b1) begin
      if (sw_seen < NUM_SWITCHES) begin
        checkOutput("sw_addr", 64'(sw_addr), 64'(sw_seen));
        checkOutput("sw_data", 64'(sw_data), 64'(exp_sw[sw_seen]));
      end else begin
        checkOutput("sw_write_overflow", 64'(sw_seen), 64'(NUM_SWITCHES - 1));
      end
      sw_seen++;
    end
  end

  initial begin
    logic [7:0] partial_sync;
    logic [4:0] noise;
    partial_sync = 8'h25;
    noise        = 5'b01101;
    reset_n   = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_bit   = 1'b0;

    $display("[TB] reset state");
    repeat (3) @(negedge clock);
    checkIdle();
    reset_n = 1'b1;
    checkOutput("ready_first_cycle", 64'(cfg_ready), 64'd0);
    @(negedge clock);
    checkOutput("ready_in_hunt", 64'(cfg_ready), 64'd1);

    $display("[TB] clean back-to-back load");
    buildStream(0);
    applyStimulus(0, TOTAL_BITS);
    checkLoaded(1);
    repeat (3) begin
      @(negedge clock);
      cfg_valid = 1'b1;
      cfg_bit   = 1'b0;
    end
    @(negedge clock);
    cfg_valid = 1'b0;
    checkOutput("done_holds", 64'(cfg_done), 64'd1);
    checkOutput("no_writes_in_done", 64'(tile_seen), 64'(NUM_TILES));

    $display("[TB] corrupted payload bit");
    pulseStart();
    checkOutput("start_clears_done", 64'(cfg_done), 64'd0);
    checkOutput("start_clears_enable", 64'(fabric_enable), 64'd0);
    checkOutput("start_ready", 64'(cfg_ready), 64'd1);
    buildStream(1);
    applyStimulus(0, TOTAL_BITS);
    checkLoaded(0);

    $display("[TB] noise and partial sync before true sync");
    pulseStart();
    buildStream(0);
    for (int i = 0; i < 5; i++) sendBit(noise[i], 0);
    for (int i = 0; i < 8; i++) sendBit(partial_sync[i], 0);
    @(negedge clock);
    cfg_valid = 1'b0;
    checkOutput("noise_no_tile_writes", 64'(tile_seen), 64'd0);
    checkOutput("noise_still_ready", 64'(cfg_ready), 64'd1);
    applyStimulus(0, TOTAL_BITS);
    checkLoaded(1);

    $display("[TB] randomly stalled valid");
    pulseStart();
    applyStimulus(1, TOTAL_BITS);
    checkLoaded(1);

    $display("[TB] restart inside tile frame 5");
    pulseStart();
    applyStimulus(0, 8 + 5*33 + 10);
    checkOutput("tiles_before_restart", 64'(tile_seen), 64'd5);
    pulseStart();
    checkOutput("restart_ready", 64'(cfg_ready), 64'd1);
    checkOutput("restart_tile_we", 64'(tile_we), 64'd0);
    checkOutput("restart_tile_addr", 64'(tile_addr), 64'd0);
    checkOutput("restart_tile_data", 64'(tile_data), 64'd0);
    applyStimulus(0, TOTAL_BITS);
    checkLoaded(1);

    $display("[TB] reset pulse during switch frames");
    pulseStart();
    applyStimulus(0, 8 + NUM_TILES*33 + 3*16 + 5);
    checkOutput("switches_before_reset", 64'(sw_seen), 64'd3);
    @(negedge clock);
    reset_n   = 1'b0;
    cfg_valid = 1'b0;
    @(negedge clock);
    checkIdle();
    reset_n   = 1'b1;
    tile_seen = 0;
    sw_seen   = 0;
    @(negedge clock);
    checkOutput("ready_after_release", 64'(cfg_ready), 64'd1);
    applyStimulus(0, TOTAL_BITS);
    checkLoaded(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
